hazard_scheduler: RTL and testbench

- Central stall/forward scheduler for the 5-stage MIPS pipeline.
- Consumes the D-stage A-T decode (A1/A2/A3, Tuse class, result-source op) and carries each in-flight instruction's destination and result source through E, M and W in its own shadow registers.
- Each cycle it decides whether D must stall and which source each forwarding mux selects.
- Also owns the mult/div busy countdown that gates HI/LO users.

---
 rtl/hazard_scheduler_pkg.sv | 45 ++++
 rtl/hazard_scheduler_if.sv | 35 +++
 rtl/hazard_scheduler_shadow_pipe.sv | 68 ++++++
 rtl/hazard_scheduler.sv | 71 +++++++
 tb/tb_hazard_scheduler.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/hazard_scheduler_pkg.sv
// Shared types and helpers for the pipeline hazard scheduler.
package hazard_scheduler_pkg;

  localparam int unsigned REG_W    = 5;
  localparam int unsigned MD_CNT_W = 4;

  typedef enum logic [1:0] {
    RES_NW  = 2'd0,
    RES_ALU = 2'd1,
    RES_DM  = 2'd2,
    RES_PC  = 2'd3
  } res_op_e;

  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_W  = 2'd1,
    FWD_M  = 2'd2,
    FWD_E  = 2'd3
  } fwd_sel_e;

  typedef struct packed {
    logic [REG_W-1:0] a1;
    logic [REG_W-1:0] a2;
    logic [REG_W-1:0] a3;
    res_op_e          res_op;
  } dec_t;

  function automatic logic [1:0] tnew_e(res_op_e op);
    case (op)
      RES_ALU: tnew_e = 2'd1;
      RES_DM:  tnew_e = 2'd2;
      default: tnew_e = 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] tnew_m(res_op_e op);
    tnew_m = (op == RES_DM) ? 2'd1 : 2'd0;
  endfunction

  // True when a stage writes register r with a real result
  function automatic logic hit(logic [REG_W-1:0] r, logic [REG_W-1:0] a3, res_op_e op);
    hit = (r != '0) && (a3 == r) && (op != RES_NW);
  endfunction

endpackage

// File: rtl/hazard_scheduler_if.sv
// D-stage decode inputs and scheduler decisions for the hazard scheduler.
interface hazard_scheduler_if;
  import hazard_scheduler_pkg::*;

  logic [REG_W-1:0] A1D;
  logic [REG_W-1:0] A2D;
  logic [REG_W-1:0] A3D;
  logic             Tuse_rs0;
  logic             Tuse_rs1;
  logic             Tuse_rt0;
  logic             Tuse_rt1;
  logic             Tuse_rt2;
  logic [1:0]       resOpD;
  logic             md_start_D;
  logic             md_use_D;
  logic             stall;
  logic [1:0]       FwdRsD;
  logic [1:0]       FwdRtD;
  logic [1:0]       FwdRsE;
  logic [1:0]       FwdRtE;
  logic [1:0]       FwdRtM;
  logic             md_busy;

  modport master (
    output A1D, A2D, A3D, Tuse_rs0, Tuse_rs1, Tuse_rt0, Tuse_rt1, Tuse_rt2,
    output resOpD, md_start_D, md_use_D,
    input  stall, FwdRsD, FwdRtD, FwdRsE, FwdRtE, FwdRtM, md_busy
  );

  modport slave (
    input  A1D, A2D, A3D, Tuse_rs0, Tuse_rs1, Tuse_rt0, Tuse_rt1, Tuse_rt2,
    input  resOpD, md_start_D, md_use_D,
    output stall, FwdRsD, FwdRtD, FwdRsE, FwdRtE, FwdRtM, md_busy
  );
endinterface

// File: rtl/hazard_scheduler_shadow_pipe.sv
// E/M/W shadow copies of in-flight decode fields plus the mult/div busy countdown.
module hazard_scheduler_shadow_pipe
  import hazard_scheduler_pkg::*;
#(
  parameter int unsigned MD_CYCLES = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  dec_t             dec_i,
  input  logic             md_start_i,
  output dec_t             e_o,
  output logic [REG_W-1:0] a2_m_o,
  output logic [REG_W-1:0] a3_m_o,
  output res_op_e          res_m_o,
  output logic [REG_W-1:0] a3_w_o,
  output res_op_e          res_w_o,
  output logic             md_busy_o
);

  dec_t                e_q, e_d;
  logic [REG_W-1:0]    a2_m_q, a2_m_d, a3_m_q, a3_m_d, a3_w_q, a3_w_d;
  res_op_e             res_m_q, res_m_d, res_w_q, res_w_d;
  logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;

  // A stalled D instruction is replaced by an all-zero bubble in E
  always_comb begin
    e_d      = '0;
    a2_m_d   = e_q.a2;
    a3_m_d   = e_q.a3;
    res_m_d  = e_q.res_op;
    a3_w_d   = a3_m_q;
    res_w_d  = res_m_q;
    md_cnt_d = md_cnt_q;
    if (!stall_i) e_d = dec_i;
    if (!stall_i && md_start_i)  md_cnt_d = MD_CNT_W'(MD_CYCLES);
    else if (md_cnt_q != '0)     md_cnt_d = md_cnt_q - MD_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q      <= '0;
      a2_m_q   <= '0;
      a3_m_q   <= '0;
      res_m_q  <= RES_NW;
      a3_w_q   <= '0;
      res_w_q  <= RES_NW;
      md_cnt_q <= '0;
    end else begin
      e_q      <= e_d;
      a2_m_q   <= a2_m_d;
      a3_m_q   <= a3_m_d;
      res_m_q  <= res_m_d;
      a3_w_q   <= a3_w_d;
      res_w_q  <= res_w_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  assign e_o       = e_q;
  assign a2_m_o    = a2_m_q;
  assign a3_m_o    = a3_m_q;
  assign res_m_o   = res_m_q;
  assign a3_w_o    = a3_w_q;
  assign res_w_o   = res_w_q;
  assign md_busy_o = (md_cnt_q != '0);

endmodule

// File: rtl/hazard_scheduler.sv
// Stall and forwarding decisions for the 5-stage pipeline, from D decode vs. shadow stages.
module hazard_scheduler
  import hazard_scheduler_pkg::*;
#(
  parameter int unsigned MD_CYCLES = 5
) (
  input  logic               clk,
  input  logic               reset,
  hazard_scheduler_if.slave  bus
);

  dec_t             dec_d, e;
  logic [REG_W-1:0] a2_m, a3_m, a3_w;
  res_op_e          res_m, res_w;
  logic             md_busy;
  logic [1:0]       tuse_rs, tuse_rt;
  logic             rs_haz, rt_haz, md_haz, stall_c;

  assign dec_d = '{a1: bus.A1D, a2: bus.A2D, a3: bus.A3D, res_op: res_op_e'(bus.resOpD)};

  hazard_scheduler_shadow_pipe #(.MD_CYCLES(MD_CYCLES)) u_shadow (
    .clk        (clk),
    .rst_n      (reset),
    .stall_i    (stall_c),
    .dec_i      (dec_d),
    .md_start_i (bus.md_start_D),
    .e_o        (e),
    .a2_m_o     (a2_m),
    .a3_m_o     (a3_m),
    .res_m_o    (res_m),
    .a3_w_o     (a3_w),
    .res_w_o    (res_w),
    .md_busy_o  (md_busy)
  );

  // A register stalls D only if a producer in E or M delivers later than D needs it
  always_comb begin
    tuse_rs = bus.Tuse_rs0 ? 2'd0 : 2'd1;
    tuse_rt = bus.Tuse_rt0 ? 2'd0 : (bus.Tuse_rt1 ? 2'd1 : 2'd2);
    rs_haz  = (bus.Tuse_rs0 || bus.Tuse_rs1) &&
              ((hit(bus.A1D, e.a3, e.res_op) && (tnew_e(e.res_op) > tuse_rs)) ||
               (hit(bus.A1D, a3_m, res_m)    && (tnew_m(res_m)    > tuse_rs)));
    rt_haz  = (bus.Tuse_rt0 || bus.Tuse_rt1 || bus.Tuse_rt2) &&
              ((hit(bus.A2D, e.a3, e.res_op) && (tnew_e(e.res_op) > tuse_rt)) ||
               (hit(bus.A2D, a3_m, res_m)    && (tnew_m(res_m)    > tuse_rt)));
    md_haz  = bus.md_use_D && md_busy;
    stall_c = rs_haz || rt_haz || md_haz;
  end

  // In E only a jal link value is ready; W never feeds D since the RF bypasses it
  function automatic fwd_sel_e fwd_d(logic [REG_W-1:0] r);
    if (hit(r, e.a3, e.res_op) && (e.res_op == RES_PC))  fwd_d = FWD_E;
    else if (hit(r, a3_m, res_m) && (tnew_m(res_m) == 2'd0)) fwd_d = FWD_M;
    else                                                  fwd_d = FWD_RF;
  endfunction

  function automatic fwd_sel_e fwd_e(logic [REG_W-1:0] r);
    if (hit(r, a3_m, res_m) && (tnew_m(res_m) == 2'd0)) fwd_e = FWD_M;
    else if (hit(r, a3_w, res_w))                        fwd_e = FWD_W;
    else                                                 fwd_e = FWD_RF;
  endfunction

  assign bus.stall   = stall_c;
  assign bus.FwdRsD  = 2'(fwd_d(bus.A1D));
  assign bus.FwdRtD  = 2'(fwd_d(bus.A2D));
  assign bus.FwdRsE  = 2'(fwd_e(e.a1));
  assign bus.FwdRtE  = 2'(fwd_e(e.a2));
  assign bus.FwdRtM  = hit(a2_m, a3_w, res_w) ? 2'(FWD_W) : 2'(FWD_RF);
  assign bus.md_busy = md_busy;

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed pipeline scenarios plus randomized decode checked against a stage-timing model.
module tb_hazard_scheduler;

  localparam int MDC = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hazard_scheduler_if bus ();
  hazard_scheduler #(.MD_CYCLES(MDC)) dut (.clk(clk), .reset(rst_n), .bus(bus));

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic [4:0] a1, a2, a3;
    logic [4:0] tu;      // {rs0, rs1, rt0, rt1, rt2}
    logic [1:0] op;
    logic       ms, mu;
    logic       st;
    logic [1:0] rsd, rtd, rse, rte, rtm;
    logic       busy;
  } vec_t;

  localparam logic [4:0] RS0 = 5'b10000, RS1 = 5'b01000;
  localparam logic [4:0] RT0 = 5'b00100, RT1 = 5'b00010, RT2 = 5'b00001;

  function automatic vec_t mk(int a1, int a2, int a3, logic [4:0] tu, int op, logic ms, logic mu,
                              logic st, int rsd, int rtd, int rse, int rte, int rtm, logic busy);
    vec_t v;
    v.a1 = 5'(a1); v.a2 = 5'(a2); v.a3 = 5'(a3); v.tu = tu; v.op = 2'(op);
    v.ms = ms; v.mu = mu; v.st = st;
    v.rsd = 2'(rsd); v.rtd = 2'(rtd); v.rse = 2'(rse); v.rte = 2'(rte); v.rtm = 2'(rtm);
    v.busy = busy;
    return v;
  endfunction

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3,
                       input logic [4:0] tu, input logic [1:0] op, input logic ms, input logic mu);
    bus.A1D = a1; bus.A2D = a2; bus.A3D = a3;
    bus.Tuse_rs0 = tu[4]; bus.Tuse_rs1 = tu[3];
    bus.Tuse_rt0 = tu[2]; bus.Tuse_rt1 = tu[1]; bus.Tuse_rt2 = tu[0];
    bus.resOpD = op; bus.md_start_D = ms; bus.md_use_D = mu;
  endtask

  task automatic check_all(input string tag, input logic st, input logic [1:0] rsd, input logic [1:0] rtd,
                           input logic [1:0] rse, input logic [1:0] rte, input logic [1:0] rtm,
                           input logic busy);
    check({tag, " stall"},   5'(bus.stall),   5'(st));
    check({tag, " FwdRsD"},  5'(bus.FwdRsD),  5'(rsd));
    check({tag, " FwdRtD"},  5'(bus.FwdRtD),  5'(rtd));
    check({tag, " FwdRsE"},  5'(bus.FwdRsE),  5'(rse));
    check({tag, " FwdRtE"},  5'(bus.FwdRtE),  5'(rte));
    check({tag, " FwdRtM"},  5'(bus.FwdRtM),  5'(rtm));
    check({tag, " md_busy"}, 5'(bus.md_busy), 5'(busy));
  endtask

  // Reference model: in-flight list indexed by distance past D (0=E, 1=M, 2=W)
  typedef struct { int a1, a2, a3, op; } ins_t;
  ins_t pipe[3];
  int   md_left;

  // Stage index at which each result kind becomes available: PC in E, ALU in M, DM in W
  function automatic int ready_at(int op);
    return (op == 1) ? 1 : (op == 2) ? 2 : 0;
  endfunction

  function automatic int tnew(int idx);
    int r;
    r = ready_at(pipe[idx].op) - idx;
    return (r > 0) ? r : 0;
  endfunction

  function automatic bit produces(int idx, int r);
    return (r != 0) && (pipe[idx].a3 == r) && (pipe[idx].op != 0);
  endfunction

  function automatic bit hazard(int r, int t);
    if (t < 0) return 1'b0;
    for (int idx = 0; idx < 2; idx++)
      if (produces(idx, r) && tnew(idx) > t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int fwd(int r, int lo, int hi);
    for (int idx = lo; idx <= hi; idx++)
      if (produces(idx, r) && tnew(idx) == 0) return 3 - idx;
    return 0;
  endfunction

  vec_t tbl[$];

  initial begin
    rst_n = 1'b0;
    drive(5'd3, 5'd3, 5'd7, RS0 | RT0, 2'd1, 1'b0, 1'b1);
    #2;
    check_all("reset", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(5'd0, 5'd0, 5'd0, 5'd0, 2'd0, 1'b0, 1'b0);

    tbl.push_back(mk(1, 2, 3, RS1 | RT1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));  // addu $3
    tbl.push_back(mk(3, 0, 0, RS0 | RT0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));  // beq $3,$0 stalls
    tbl.push_back(mk(3, 0, 0, RS0 | RT0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0));  // from M
    tbl.push_back(mk(1, 5, 5, RS1,       2, 0, 0, 0, 0, 0, 1, 0, 0, 0));  // lw $5; beq rs from W
    tbl.push_back(mk(5, 5, 6, RS1 | RT1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0));  // addu $6,$5,$5
    tbl.push_back(mk(5, 5, 6, RS1 | RT1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 31, 5'd0,     3, 0, 0, 0, 0, 0, 1, 1, 0, 0));  // jal
    tbl.push_back(mk(31, 0, 0, RS0,      0, 0, 0, 0, 3, 0, 0, 0, 0, 0));  // jr $31
    tbl.push_back(mk(2, 4, 4, RS1,       2, 0, 0, 0, 0, 0, 2, 0, 0, 0));  // lw $4
    tbl.push_back(mk(1, 4, 0, RS1 | RT2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));  // sw $4
    tbl.push_back(mk(0, 0, 0, 5'd0,      0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 5'd0,      0, 0, 0, 0, 0, 0, 0, 0, 1, 0));  // sw data from W
    tbl.push_back(mk(1, 2, 0, RS1 | RT1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));  // mult
    for (int k = 0; k < MDC; k++)
      tbl.push_back(mk(0, 0, 7, 5'd0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 1));     // mfhi held
    tbl.push_back(mk(0, 0, 7, 5'd0,      1, 0, 1, 0, 0, 0, 0, 0, 0, 0));  // mfhi issues
    tbl.push_back(mk(1, 2, 0, RS1 | RT1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));  // addu $0
    tbl.push_back(mk(0, 0, 0, RS0 | RT0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));  // beq $0,$0
    tbl.push_back(mk(7, 7, 0, RS0 | RT0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));  // $7 only in W

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].a1, tbl[i].a2, tbl[i].a3, tbl[i].tu, tbl[i].op, tbl[i].ms, tbl[i].mu);
      #1;
      check_all($sformatf("row%0d", i), tbl[i].st, tbl[i].rsd, tbl[i].rtd, tbl[i].rse,
                tbl[i].rte, tbl[i].rtm, tbl[i].busy);
    end

    // Reset pulled while mfhi is stalled behind a busy multiplier
    @(negedge clk);
    drive(5'd1, 5'd2, 5'd0, RS1 | RT1, 2'd0, 1'b1, 1'b1);
    #1;
    check_all("mult", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    @(negedge clk);
    drive(5'd0, 5'd0, 5'd8, 5'd0, 2'd1, 1'b0, 1'b1);
    #1;
    check_all("mfhi busy", 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_all("mid-stall reset", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all("after release", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);

    // Randomized decode against the model, from a fresh reset
    @(negedge clk);
    rst_n = 1'b0;
    drive(5'd0, 5'd0, 5'd0, 5'd0, 2'd0, 1'b0, 1'b0);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) pipe[k] = '{0, 0, 0, 0};
    md_left = 0;
    for (int i = 0; i < 400; i++) begin
      int a1, a2, a3, op, trs, trt;
      logic ms, mu, est;
      logic [4:0] tu;
      a1  = int'($urandom_range(0, 3));
      a2  = int'($urandom_range(0, 3));
      a3  = int'($urandom_range(0, 3));
      op  = int'($urandom_range(0, 3));
      trs = int'($urandom_range(0, 2)) - 1;
      trt = int'($urandom_range(0, 3)) - 1;
      ms  = ($urandom_range(0, 9) == 0);
      mu  = ms | ($urandom_range(0, 7) == 0);
      tu  = {trs == 0, trs == 1, trt == 0, trt == 1, trt == 2};
      drive(5'(a1), 5'(a2), 5'(a3), tu, 2'(op), ms, mu);
      #1;
      est = hazard(a1, trs) || hazard(a2, trt) || (mu && md_left > 0);
      check_all($sformatf("rnd%0d", i), est, 2'(fwd(a1, 0, 1)), 2'(fwd(a2, 0, 1)),
                2'(fwd(pipe[0].a1, 1, 2)), 2'(fwd(pipe[0].a2, 1, 2)),
                2'(fwd(pipe[1].a2, 2, 2)), md_left > 0);
      @(posedge clk);
      if (!est && ms)       md_left = MDC;
      else if (md_left > 0) md_left--;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = est ? '{0, 0, 0, 0} : '{a1, a2, a3, op};
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
